// File: rtl/chan_merge_pkg.sv
// Shared types and constants for the chan_merge packet-level stream merger.
package chan_merge_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_ABORT  = 2'd2
   } state_e;

   localparam logic [31:0] ABORT_WORD_DEF = 32'hDEAD_BEEF;
   localparam int          PKT_CNT_W_DEF  = 16;
   localparam int          ABORT_CNT_W    = 8;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/chan_merge_rr_arbiter.sv
// Combinational round-robin finder: first requesting channel after last_grant_i.
module chan_rr_arbiter
   import chan_merge_pkg::*;
#(
   parameter int NUM_CHAN = 4,
   parameter int IDX_W    = idx_width(NUM_CHAN)
) (
   input  logic [NUM_CHAN-1:0] req_i,
   input  logic [IDX_W-1:0]    last_grant_i,
   output logic                hit_o,
   output logic [IDX_W-1:0]    grant_o
);

   // scan last_grant+1 .. last_grant+NUM_CHAN, wrapping, first hit wins
   always_comb begin
      logic [IDX_W-1:0] cand;
      hit_o   = 1'b0;
      grant_o = '0;
      cand    = '0;
      for (int k = 1; k <= NUM_CHAN; k++) begin
         cand = IDX_W'((int'(last_grant_i) + k) % NUM_CHAN);
         if (!hit_o && req_i[cand]) begin
            hit_o   = 1'b1;
            grant_o = cand;
         end else begin
            hit_o   = hit_o;
         end
      end
   end

endmodule

// File: rtl/chan_merge.sv
// Merges NUM_CHAN link channels into one AXI4-stream, packet-level round robin,
// with an abort beat when a granted link drops mid-packet.
module chan_merge
   import chan_merge_pkg::*;
#(
   parameter int          NUM_CHAN   = 4,
   parameter int          DATA_W     = 32,
   parameter int          CNT_W      = PKT_CNT_W_DEF,
   parameter logic [31:0] ABORT_WORD = ABORT_WORD_DEF,
   localparam int         KEEP_W     = DATA_W / 8,
   localparam int         IDX_W      = idx_width(NUM_CHAN)
) (
   input  logic                            axis_aclk,
   input  logic                            axis_aresetn,
   input  logic [NUM_CHAN*DATA_W-1:0]      s_axis_tdata,
   input  logic [NUM_CHAN*KEEP_W-1:0]      s_axis_tkeep,
   input  logic [NUM_CHAN-1:0]             s_axis_tvalid,
   input  logic [NUM_CHAN-1:0]             s_axis_tlast,
   output logic [NUM_CHAN-1:0]             s_axis_tready,
   input  logic [NUM_CHAN-1:0]             channel_up,
   input  logic [NUM_CHAN-1:0]             chan_en,
   input  logic                            cnt_clear,
   output logic [DATA_W-1:0]               m_axis_tdata,
   output logic [KEEP_W-1:0]               m_axis_tkeep,
   output logic                            m_axis_tvalid,
   output logic                            m_axis_tlast,
   output logic [IDX_W-1:0]                m_axis_tdest,
   output logic                            m_axis_tuser,
   input  logic                            m_axis_tready,
   output logic [NUM_CHAN*CNT_W-1:0]       pkt_cnt,
   output logic [NUM_CHAN*ABORT_CNT_W-1:0] abort_cnt,
   output logic                            busy
);

   state_e                 state_q, state_d;
   logic [IDX_W-1:0]       grant_q, grant_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [CNT_W-1:0]       pkt_cnt_q   [NUM_CHAN];
   logic [ABORT_CNT_W-1:0] abort_cnt_q [NUM_CHAN];
   logic [NUM_CHAN-1:0]    elig_s;
   logic                   arb_hit_s;
   logic [IDX_W-1:0]       arb_grant_s;
   logic                   hs_s;
   logic                   pkt_inc_s;
   logic                   abort_inc_s;

   assign elig_s = chan_en & channel_up & s_axis_tvalid;

   chan_rr_arbiter #(
      .NUM_CHAN (NUM_CHAN),
      .IDX_W    (IDX_W)
   ) u_arb (
      .req_i        (elig_s),
      .last_grant_i (last_q),
      .hit_o        (arb_hit_s),
      .grant_o      (arb_grant_s)
   );

   // next-state and stream outputs; chan_en is only consulted when choosing a grant
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      last_d        = last_q;
      pkt_inc_s     = 1'b0;
      abort_inc_s   = 1'b0;
      hs_s          = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      m_axis_tdest  = '0;
      m_axis_tuser  = 1'b0;
      s_axis_tready = '0;
      case (state_q)
         ST_IDLE: begin
            if (arb_hit_s) begin
               grant_d = arb_grant_s;
               state_d = ST_STREAM;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_STREAM: begin
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tdata           = s_axis_tdata[int'(grant_q)*DATA_W +: DATA_W];
            m_axis_tkeep           = s_axis_tkeep[int'(grant_q)*KEEP_W +: KEEP_W];
            m_axis_tlast           = s_axis_tlast[grant_q];
            m_axis_tdest           = grant_q;
            s_axis_tready[grant_q] = m_axis_tready;
            hs_s                   = s_axis_tvalid[grant_q] & m_axis_tready;
            // a completing tlast wins over a link drop in the same cycle
            if (hs_s && s_axis_tlast[grant_q]) begin
               pkt_inc_s = 1'b1;
               last_d    = grant_q;
               state_d   = ST_IDLE;
            end else if (!channel_up[grant_q]) begin
               state_d   = ST_ABORT;
            end else begin
               state_d   = ST_STREAM;
            end
         end
         ST_ABORT: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = DATA_W'(ABORT_WORD);
            m_axis_tkeep  = '1;
            m_axis_tlast  = 1'b1;
            m_axis_tuser  = 1'b1;
            m_axis_tdest  = grant_q;
            if (m_axis_tready) begin
               abort_inc_s = 1'b1;
               last_d      = grant_q;
               state_d     = ST_IDLE;
            end else begin
               state_d     = ST_ABORT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state, grant and round-robin pointer; pointer resets so channel 0 is searched first
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= IDX_W'(NUM_CHAN - 1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
      end
   end

   // per-channel counters; clear beats a same-cycle increment
   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            pkt_cnt_q[c]   <= '0;
            abort_cnt_q[c] <= '0;
         end
      end else if (cnt_clear) begin
         for (int c = 0; c < NUM_CHAN; c++) begin
            pkt_cnt_q[c]   <= '0;
            abort_cnt_q[c] <= '0;
         end
      end else begin
         if (pkt_inc_s) begin
            pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + CNT_W'(1);
         end
         if (abort_inc_s) begin
            abort_cnt_q[grant_q] <= abort_cnt_q[grant_q] + ABORT_CNT_W'(1);
         end
      end
   end

   for (genvar c = 0; c < NUM_CHAN; c++) begin : g_cnt
      assign pkt_cnt[c*CNT_W +: CNT_W]                 = pkt_cnt_q[c];
      assign abort_cnt[c*ABORT_CNT_W +: ABORT_CNT_W]   = abort_cnt_q[c];
   end

   assign busy = (state_q != ST_IDLE);

endmodule
